fast_pyramid_corner_merger: RTL and testbench
=============================================

// Module: fast_pyramid_corner_merger
// PURPOSE
//  Merges corner events from NUM_LEVELS FAST+NMS pipelines (one per pyramid level) into one stream.
//  Rescales each level's coordinates to full-resolution space, caps corners per frame and buffers them.
//  Presents them on a valid/ready interface for the downstream descriptor/DMA stage.
//  Sits after the per-level NMS outputs; the FAST pipelines cannot stall, so input-side loss is counted, never back-pressured.
// PARAMETERS
//  NUM_LEVELS      2     number of pyramid levels (input channels), >=1
//  COORD_WIDTH     10    input x/y width per level
//  OUT_COORD_WIDTH 12    output x/y width, >= COORD_WIDTH+(NUM_LEVELS-1)*SCALE_SHIFT
//  SCORE_WIDTH     13    corner score width
//  SCALE_SHIFT     1     log2 downscale factor between adjacent levels
//  FIFO_DEPTH      16    output FIFO entries, power of 2
//  MAX_CORNERS     1024  corners accepted per frame; excess dropped
// PORTS
//  clk            in   1                        clock, all logic on rising edge
//  rst            in   1                        synchronous, active-high reset
//  ce             in   1                        input capture enable; output side ignores ce
//  sof            in   1                        start-of-frame pulse
//  eof            in   1                        end-of-frame pulse (all levels finished)
//  corner_vld     in   NUM_LEVELS               per-level corner strobe
//  x_in           in   NUM_LEVELS*COORD_WIDTH   per-level x, level i in bits [i*CW +: CW]
//  y_in           in   NUM_LEVELS*COORD_WIDTH   per-level y, same packing
//  score_in       in   NUM_LEVELS*SCORE_WIDTH   per-level score
//  m_vld          out  1                        output corner valid
//  m_rdy          in   1                        downstream ready
//  m_x, m_y       out  OUT_COORD_WIDTH          full-resolution coordinates
//  m_score        out  SCORE_WIDTH              score, passed unmodified
//  m_level        out  $clog2(NUM_LEVELS)|1     source level
//  frame_cnt      out  $clog2(MAX_CORNERS+1)    corners accepted this frame
//  drop_cnt       out  16                       dropped corners this frame, saturating
//  frame_done     out  1                        one-cycle pulse, frame fully drained
// BEHAVIOUR
//  Reset: state IDLE, FIFO and hold regs empty, every output 0.
//  FSM: IDLE -sof-> ACTIVE -eof-> DRAIN -(hold regs and FIFO empty)-> IDLE, pulsing frame_done.
//   sof in ACTIVE/DRAIN goes to ACTIVE and clears frame_cnt/drop_cnt; FIFO contents kept.
//   sof and eof in same cycle: sof wins, eof ignored.
//  Capture: ACTIVE && ce && corner_vld[i] loads hold reg i with x,y,score.
//   Capture is blocked if hold reg i stays full this cycle (full and not granted); the event is dropped, drop_cnt+1.
//   corner_vld is ignored in IDLE/DRAIN and when ce=0; these events are not counted.
//  Cap: if frame_cnt==MAX_CORNERS, a capture is dropped (drop_cnt+1) instead of loaded.
//   frame_cnt increments on each load into a hold reg.
//   Drops from several levels in one cycle add their count; drop_cnt saturates at 16'hFFFF.
//  Arbiter: round-robin over full hold regs, at most one grant per cycle, only when FIFO not full.
//   Pointer moves to granted+1 mod NUM_LEVELS. Search starts at pointer; pointer resets to 0.
//   A granted hold reg may be reloaded in the same cycle.
//  Scaling at FIFO write: x_out = zero_ext(x_in) << (level*SCALE_SHIFT); y the same.
//  FIFO: first-word fall-through. m_vld = !empty; pop on m_vld && m_rdy.
//   Write and pop in the same cycle on a full FIFO are both allowed.
//   Outputs hold stable while m_vld && !m_rdy.
//  Latency, no contention: corner_vld at edge t -> hold reg at t -> FIFO write at t+1 -> m_vld high after edge t+1.
//  Sustained rate: one corner per cycle total across all levels.
//  rst mid-frame: everything cleared at once; buffered corners lost; no frame_done pulse.
// TESTING
//  1 NUM_LEVELS=2. sof; L0 (x=5,y=7,s=100); L1 (x=5,y=7,s=90) two cycles later; m_rdy=1
//    -> m_x/m_y (5,7) lvl0, then (10,14) lvl1; 2-cycle latency each; frame_cnt=2.
//  2 Both levels strobe every cycle for 8 cycles, m_rdy=1
//    -> grants alternate L0,L1; drop_cnt=7 (hold reg conflicts); output order by round-robin.
//  3 MAX_CORNERS=4; 6 L0 corners spaced 2 cycles apart -> 4 outputs, frame_cnt=4, drop_cnt=2.
//  4 m_rdy=0; 20 spaced corners, FIFO_DEPTH=16 -> 16 buffered + 1 held in L0 hold reg, 3 dropped.
//    Then m_rdy=1 -> 17 emitted in order; m_x stable while stalled.
//  5 eof with 3 queued corners, m_rdy toggling -> frame_done pulses once, cycle after last pop.
//    Corners after eof are ignored; sof+eof together -> ACTIVE, counters cleared.
//  6 rst asserted mid-frame with FIFO non-empty -> m_vld=0, counters 0 next cycle; no frame_done.

Source files
------------

// File: rtl/fast_pyramid_corner_merger.sv
// Merges per-level FAST/NMS corner strobes into one full-resolution stream.
// Per-level hold regs feed a round-robin arbiter that writes a first-word fall-through FIFO.
module fast_pyramid_corner_merger #(
  parameter int unsigned NUM_LEVELS      = 2,
  parameter int unsigned COORD_WIDTH     = 10,
  parameter int unsigned OUT_COORD_WIDTH = 12,
  parameter int unsigned SCORE_WIDTH     = 13,
  parameter int unsigned SCALE_SHIFT     = 1,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_CORNERS     = 1024,
  localparam int unsigned LVL_W = $clog2(NUM_LEVELS) | 1,
  localparam int unsigned CNT_W = $clog2(MAX_CORNERS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              sof,
  input  logic                              eof,
  input  logic [NUM_LEVELS-1:0]             corner_vld,
  input  logic [NUM_LEVELS*COORD_WIDTH-1:0] x_in,
  input  logic [NUM_LEVELS*COORD_WIDTH-1:0] y_in,
  input  logic [NUM_LEVELS*SCORE_WIDTH-1:0] score_in,
  output logic                              m_vld,
  input  logic                              m_rdy,
  output logic [OUT_COORD_WIDTH-1:0]        m_x,
  output logic [OUT_COORD_WIDTH-1:0]        m_y,
  output logic [SCORE_WIDTH-1:0]            m_score,
  output logic [LVL_W-1:0]                  m_level,
  output logic [CNT_W-1:0]                  frame_cnt,
  output logic [15:0]                       drop_cnt,
  output logic                              frame_done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  typedef struct packed {
    logic [OUT_COORD_WIDTH-1:0] x;
    logic [OUT_COORD_WIDTH-1:0] y;
    logic [SCORE_WIDTH-1:0]     s;
    logic [LVL_W-1:0]           lvl;
  } entry_t;

  state_e state;

  logic [NUM_LEVELS-1:0]  hold_full;
  logic [COORD_WIDTH-1:0] hold_x [NUM_LEVELS];
  logic [COORD_WIDTH-1:0] hold_y [NUM_LEVELS];
  logic [SCORE_WIDTH-1:0] hold_s [NUM_LEVELS];

  entry_t         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           can_write;
  entry_t         wr_entry;
  entry_t         head;

  logic [LVL_W-1:0]      rr_ptr;
  logic                  grant_vld;
  logic [LVL_W-1:0]      grant_idx;
  logic [NUM_LEVELS-1:0] grant_oh;
  int unsigned           arb_cand;

  logic [NUM_LEVELS-1:0] load;
  int unsigned           run_cnt;
  int unsigned           n_load;
  int unsigned           n_drop;
  int unsigned           drop_sum;
  logic [CNT_W-1:0]      cnt_next;
  logic [15:0]           drop_next;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign m_vld      = !fifo_empty;
  assign pop        = m_vld && m_rdy;
  // A simultaneous pop frees the slot, so a full FIFO can still accept a write.
  assign can_write  = !fifo_full || pop;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    arb_cand  = 0;
    for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
      arb_cand = 32'(rr_ptr) + k;
      if (arb_cand >= NUM_LEVELS) arb_cand = arb_cand - NUM_LEVELS;
      if (can_write && !grant_vld && hold_full[arb_cand]) begin
        grant_vld = 1'b1;
        grant_idx = LVL_W'(arb_cand);
      end
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // Levels are visited in index order so the cap is never overshot within one cycle.
  always_comb begin
    load    = '0;
    n_load  = 0;
    n_drop  = 0;
    run_cnt = 32'(frame_cnt);
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (state == StActive && ce && corner_vld[i]) begin
        if ((hold_full[i] && !grant_oh[i]) || run_cnt == MAX_CORNERS) begin
          n_drop = n_drop + 1;
        end else begin
          load[i] = 1'b1;
          run_cnt = run_cnt + 1;
          n_load  = n_load + 1;
        end
      end
    end
    cnt_next  = (sof ? '0 : frame_cnt) + CNT_W'(n_load);
    drop_sum  = (sof ? 32'd0 : 32'(drop_cnt)) + n_drop;
    drop_next = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    wr_entry.lvl = grant_idx;
    wr_entry.s   = hold_s[grant_idx];
    wr_entry.x   = OUT_COORD_WIDTH'(hold_x[grant_idx]) << (32'(grant_idx) * SCALE_SHIFT);
    wr_entry.y   = OUT_COORD_WIDTH'(hold_y[grant_idx]) << (32'(grant_idx) * SCALE_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= '0;
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
        hold_x[i] <= '0;
        hold_y[i] <= '0;
        hold_s[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
        if (load[i]) begin
          hold_full[i] <= 1'b1;
          hold_x[i]    <= x_in[i*COORD_WIDTH +: COORD_WIDTH];
          hold_y[i]    <= y_in[i*COORD_WIDTH +: COORD_WIDTH];
          hold_s[i]    <= score_in[i*SCORE_WIDTH +: SCORE_WIDTH];
        end else if (grant_oh[i]) begin
          hold_full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (32'(grant_idx) + 1 >= NUM_LEVELS) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (grant_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({grant_vld, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (grant_vld) fifo_mem[wr_ptr] <= wr_entry;
  end

  assign head    = fifo_mem[rd_ptr];
  assign m_x     = m_vld ? head.x   : '0;
  assign m_y     = m_vld ? head.y   : '0;
  assign m_score = m_vld ? head.s   : '0;
  assign m_level = m_vld ? head.lvl : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_cnt  <= cnt_next;
      drop_cnt   <= drop_next;
      frame_done <= 1'b0;
      if (sof) begin
        state <= StActive;
      end else begin
        case (state)
          StActive: if (eof) state <= StDrain;
          StDrain: begin
            if (!(|hold_full) && fifo_empty) begin
              state      <= StIdle;
              frame_done <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_pyramid_corner_merger.sv
// Bench for fast_pyramid_corner_merger: queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations. A second instance exercises the corner cap.
module tb_fast_pyramid_corner_merger;

  localparam int CW = 10;
  localparam int SW = 13;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        cap_ce = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic        m_rdy = 1'b1;
  logic        cap_rdy = 1'b1;
  logic [1:0]  corner_vld = '0;
  logic [19:0] x_in = '0;
  logic [19:0] y_in = '0;
  logic [25:0] score_in = '0;

  logic        m_vld, frame_done, c_vld, c_done;
  logic [11:0] m_x, m_y, c_x, c_y;
  logic [12:0] m_score, c_score;
  logic [0:0]  m_level, c_level;
  logic [10:0] frame_cnt;
  logic [2:0]  c_frame;
  logic [15:0] drop_cnt, c_drop;

  fast_pyramid_corner_merger u_dut (
    .clk(clk), .rst(rst), .ce(ce), .sof(sof), .eof(eof), .corner_vld(corner_vld),
    .x_in(x_in), .y_in(y_in), .score_in(score_in), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_x(m_x), .m_y(m_y), .m_score(m_score), .m_level(m_level), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .frame_done(frame_done)
  );

  fast_pyramid_corner_merger #(.MAX_CORNERS(4)) u_cap (
    .clk(clk), .rst(rst), .ce(cap_ce), .sof(sof), .eof(eof), .corner_vld(corner_vld),
    .x_in(x_in), .y_in(y_in), .score_in(score_in), .m_vld(c_vld), .m_rdy(cap_rdy),
    .m_x(c_x), .m_y(c_y), .m_score(c_score), .m_level(c_level), .frame_cnt(c_frame),
    .drop_cnt(c_drop), .frame_done(c_done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int s; int l;} ent_t;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  ent_t mq[$];
  bit   mfull[2];
  int   mhx[2], mhy[2], mhs[2];
  int   mptr, mstate, mframe, mdrop;
  bit   mdone;

  ent_t log_q[$];
  int   cap_pops = 0;
  int   done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: hold slots, a bounded queue, and per-frame counters.
  task automatic model_step();
    bit pop, hold_empty, q_empty;
    bit ld[2];
    int g, run, nl, nd, bf, bd;
    if (rst) begin
      mq.delete();
      mfull = '{0, 0};
      mptr = 0; mstate = 0; mframe = 0; mdrop = 0; mdone = 0;
      return;
    end
    hold_empty = !mfull[0] && !mfull[1];
    q_empty = (mq.size() == 0);
    pop = !q_empty && m_rdy;
    g = -1;
    if (mq.size() < 16 || pop)
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (mptr + k) % 2;
        if (g < 0 && mfull[idx]) g = idx;
      end
    run = mframe; nl = 0; nd = 0; ld = '{0, 0};
    for (int i = 0; i < 2; i++)
      if (mstate == 1 && ce && corner_vld[i]) begin
        if ((mfull[i] && g != i) || run == MAXC) nd++;
        else begin ld[i] = 1; run++; nl++; end
      end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back('{mhx[g] << g, mhy[g] << g, mhs[g], g});
      mfull[g] = 0;
      mptr = (g + 1) % 2;
    end
    for (int i = 0; i < 2; i++)
      if (ld[i]) begin
        mfull[i] = 1;
        mhx[i] = int'(x_in[i*CW +: CW]);
        mhy[i] = int'(y_in[i*CW +: CW]);
        mhs[i] = int'(score_in[i*SW +: SW]);
      end
    bf = sof ? 0 : mframe;
    bd = sof ? 0 : mdrop;
    mframe = bf + nl;
    mdrop = (bd + nd > 65535) ? 65535 : bd + nd;
    mdone = 0;
    if (sof) mstate = 1;
    else if (mstate == 1 && eof) mstate = 2;
    else if (mstate == 2 && hold_empty && q_empty) begin mstate = 0; mdone = 1; end
  endtask

  // Pre-edge DUT values are visible here, so this logs exactly the pops taken at this edge.
  initial forever begin
    @(posedge clk);
    if (m_vld === 1'b1 && m_rdy) log_q.push_back('{int'(m_x), int'(m_y), int'(m_score), int'(m_level)});
    if (c_vld === 1'b1) cap_pops++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("m_vld", m_vld, mq.size() != 0);
      if (mq.size() != 0) begin
        check("m_x", m_x, mq[0].x);
        check("m_y", m_y, mq[0].y);
        check("m_score", m_score, mq[0].s);
        check("m_level", m_level, mq[0].l);
      end
      check("frame_cnt", frame_cnt, mframe);
      check("drop_cnt", drop_cnt, mdrop);
      check("frame_done", frame_done, mdone);
    end
    if (frame_done === 1'b1) done_pulses++;
  end

  task automatic cyc();
    @(negedge clk);
    sof = 1'b0;
    eof = 1'b0;
    corner_vld = '0;
  endtask

  task automatic set_corner(input int lvl, input int x, input int y, input int s);
    corner_vld[lvl] = 1'b1;
    x_in[lvl*CW +: CW] = x[CW-1:0];
    y_in[lvl*CW +: CW] = y[CW-1:0];
    score_in[lvl*SW +: SW] = s[SW-1:0];
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin cyc(); n++; end
    check(name, n < 200, 1);
  endtask

  task automatic wait_pops(input string name, input int k);
    int n;
    n = 0;
    while (log_q.size() < k && n < 300) begin cyc(); n++; end
    check(name, log_q.size(), k);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int start_pulses;
    repeat (3) cyc();
    check("rst_m_vld", m_vld, 0);
    check("rst_m_x", m_x, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single corners on each level, two-cycle latency, L1 scaled by 2.
    log_q.delete();
    cyc(); sof = 1'b1;
    cyc(); set_corner(0, 5, 7, 100);
    cyc(); check("t1_lat_l0", m_vld, 0);
    cyc(); check("t1_l0_vld", m_vld, 1);
    check("t1_l0_x", m_x, 5); check("t1_l0_y", m_y, 7);
    check("t1_l0_lvl", m_level, 0); check("t1_l0_s", m_score, 100);
    set_corner(1, 5, 7, 90);
    cyc(); check("t1_lat_l1", m_vld, 0);
    cyc(); check("t1_l1_vld", m_vld, 1);
    check("t1_l1_x", m_x, 10); check("t1_l1_y", m_y, 14);
    check("t1_l1_lvl", m_level, 1); check("t1_l1_s", m_score, 90);
    check("t1_frame_cnt", frame_cnt, 2);
    cyc(); eof = 1'b1;
    wait_done("t1_done");

    // Both levels every cycle: one hold-reg conflict per cycle after the first.
    log_q.delete();
    cyc(); sof = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); set_corner(0, 10 + i, i, 200 + i); set_corner(1, 20 + i, i, 300 + i);
    end
    cyc();
    check("t2_drop_cnt", drop_cnt, 7);
    check("t2_frame_cnt", frame_cnt, 9);
    wait_pops("t2_pops", 9);
    for (int k = 0; k < 9; k++) check("t2_rr_order", log_q[k].l, k % 2);
    check("t2_first_x", log_q[0].x, 10);
    check("t2_second_x", log_q[1].x, 40);
    cyc(); eof = 1'b1;
    wait_done("t2_done");

    // Corner cap on the MAX_CORNERS=4 instance; main instance has ce low and must ignore.
    ce = 1'b0; cap_ce = 1'b1; cap_pops = 0;
    cyc(); sof = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); set_corner(0, i + 1, i, i);
      cyc();
    end
    repeat (4) cyc();
    check("t3_cap_pops", cap_pops, 4);
    check("t3_cap_frame", c_frame, 4);
    check("t3_cap_drop", c_drop, 2);
    check("t3_ce_off_frame", frame_cnt, 0);
    check("t3_ce_off_drop", drop_cnt, 0);
    cap_ce = 1'b0; ce = 1'b1;
    cyc(); eof = 1'b1;
    wait_done("t3_done");

    // Stalled output: FIFO fills, one corner waits in the hold reg, the rest drop.
    m_rdy = 1'b0;
    log_q.delete();
    cyc(); sof = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); set_corner(0, i + 1, 2 * i, i);
      cyc();
    end
    cyc();
    check("t4_frame_cnt", frame_cnt, 17);
    check("t4_drop_cnt", drop_cnt, 3);
    check("t4_vld", m_vld, 1);
    check("t4_head_x", m_x, 1);
    repeat (3) cyc();
    check("t4_stable_x", m_x, 1);
    m_rdy = 1'b1;
    wait_pops("t4_pops", 17);
    for (int k = 0; k < 17; k++) check("t4_order", log_q[k].x, k + 1);
    cyc(); eof = 1'b1;
    wait_done("t4_done");

    // Drain with toggling ready; post-eof corner ignored; then sof+eof together.
    m_rdy = 1'b0;
    start_pulses = done_pulses;
    cyc(); sof = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); set_corner(1, i, i, i);
      cyc();
    end
    cyc(); eof = 1'b1;
    cyc(); set_corner(0, 9, 9, 9);
    for (int n = 0; n < 30; n++) begin
      cyc(); m_rdy = ~m_rdy;
    end
    m_rdy = 1'b1;
    check("t5_done_once", done_pulses - start_pulses, 1);
    check("t5_frame_cnt", frame_cnt, 3);
    check("t5_vld", m_vld, 0);
    cyc(); sof = 1'b1; eof = 1'b1;
    cyc(); check("t5_sof_clear", frame_cnt, 0);
    set_corner(0, 3, 3, 3);
    cyc(); check("t5_active", frame_cnt, 1);

    // Reset mid-frame with corners buffered.
    m_rdy = 1'b0;
    cyc(); set_corner(0, 4, 4, 4);
    cyc(); cyc();
    check("t6_pre_vld", m_vld, 1);
    start_pulses = done_pulses;
    rst = 1'b1;
    cyc();
    check("t6_vld", m_vld, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_drop_cnt", drop_cnt, 0);
    check("t6_done", frame_done, 0);
    rst = 1'b0; m_rdy = 1'b1;
    repeat (5) cyc();
    check("t6_no_done", done_pulses - start_pulses, 0);
    check("t6_still_empty", m_vld, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
